// File: rtl/imem_port_sequencer.sv
// Owns the single-port instruction memory: arbitrates between pipeline fetch
// reads and a program-load write stream, with one-cycle read latency and flush.
module imem_port_sequencer #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              fetch_flush,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {HALT, LOAD, DONE, RUN} state_t;
  localparam state_t RESET_STATE = BOOT_LOAD ? HALT : RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic [ADDR_W:0]   count, count_nxt;
  logic              rd_fire;
  logic              vld_p1;

  // Outputs are gated by rst_n so the port stays idle while reset is held,
  // even when the reset state is RUN.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    load_ready  = 1'b0;
    load_done   = 1'b0;
    fetch_ready = 1'b0;
    rd_fire     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (rst_n) begin
      case (state)
        HALT: begin
          if (load_start) begin
            state_nxt = LOAD;
            count_nxt = '0;
          end
        end
        LOAD: begin
          load_ready = (count < len);
          if (load_valid && load_ready) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = base + count[ADDR_W-1:0];
            mem_wdata = load_data;
            count_nxt = count + 1'b1;
          end
          // Leave on the edge after the final write (or at once for len=0).
          if (count_nxt == len) state_nxt = DONE;
        end
        DONE: begin
          load_done = 1'b1;
          state_nxt = RUN;
        end
        RUN: begin
          fetch_ready = ~load_start & ~fetch_flush;
          rd_fire     = fetch_req & fetch_ready;
          if (rd_fire) begin
            mem_en   = 1'b1;
            mem_addr = fetch_addr;
          end
          if (load_start) begin
            state_nxt = LOAD;
            count_nxt = '0;
          end
        end
        default: state_nxt = RESET_STATE;
      endcase
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RESET_STATE;
      count  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      vld_p1 <= rd_fire;
    end
  end

  // Load descriptor is plain data, captured only when a load is accepted.
  always_ff @(posedge clk) begin
    if (load_start && (state == HALT || state == RUN)) begin
      base <= load_base;
      len  <= load_len;
    end
  end

  // Response stage: memory data arrives one cycle after the accepted read
  assign fetch_valid = vld_p1 & ~fetch_flush;
  assign fetch_instr = fetch_valid ? mem_rdata : '0;
  assign busy        = (state != RUN);

endmodule
